// File: rtl/mux_demux_sched_2.sv
// Two-lane round-robin issue scheduler in front of the shared 2:1 mux / 1:2 demux path.
// Registers sel/path_inp, tracks in-flight ops with a LAT+1 tag pipe, holds results under valid/ready.
module mux_demux_sched_2 #(
    parameter int ID    = 1,
    parameter int WIDTH = 2,
    parameter int LAT   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            in_valid,
    input  logic [1:0][WIDTH-1:0] in_data,
    output logic [1:0]            in_ready,
    output logic                  sel,
    output logic [1:0][WIDTH-1:0] path_inp,
    input  logic [1:0][WIDTH-1:0] path_outp,
    output logic [1:0]            out_valid,
    output logic [1:0][WIDTH-1:0] out_data,
    input  logic [1:0]            out_ready
);

    // ID has no function; an out-of-range parameter set shows up as this named block in the netlist.
    if (ID < 0 || LAT < 0 || LAT > 8) begin : g_param_out_of_range
    end

    logic                  sel_q, sel_d;
    logic [1:0][WIDTH-1:0] path_inp_q, path_inp_d;
    logic [1:0]            out_valid_q, out_valid_d;
    logic [1:0][WIDTH-1:0] out_data_q, out_data_d;
    logic                  last_q, last_d;
    logic [LAT:0]          tag_v_q, tag_v_d;
    logic [LAT:0]          tag_lane_q, tag_lane_d;

    logic [1:0] inflight;
    logic [1:0] busy;
    logic [1:0] elig;
    logic [1:0] grant;
    logic       issue;
    logic       issue_lane;
    logic       cap_v;
    logic       cap_lane;

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= LAT; i++) begin
            if (tag_v_q[i]) begin
                inflight[tag_lane_q[i]] = 1'b1;
            end
        end
    end

    // A slot being drained this cycle is already free, so a lane can re-issue on its drain cycle.
    always_comb begin
        busy       = inflight | (out_valid_q & ~out_ready);
        elig       = in_valid & ~busy;
        grant      = (elig == 2'b11) ? (last_q ? 2'b01 : 2'b10) : elig;
        in_ready   = rst ? 2'b00 : grant;
        issue      = |in_ready;
        issue_lane = in_ready[1];
    end

    always_comb begin
        sel_d      = sel_q;
        path_inp_d = path_inp_q;
        last_d     = last_q;
        if (issue) begin
            sel_d                  = issue_lane;
            path_inp_d[issue_lane] = in_data[issue_lane];
            last_d                 = issue_lane;
        end
    end

    always_comb begin
        tag_v_d       = '0;
        tag_lane_d    = '0;
        tag_v_d[0]    = issue;
        tag_lane_d[0] = issue_lane;
        for (int i = 1; i <= LAT; i++) begin
            tag_v_d[i]    = tag_v_q[i-1];
            tag_lane_d[i] = tag_lane_q[i-1];
        end
    end

    always_comb begin
        cap_v       = tag_v_q[LAT];
        cap_lane    = tag_lane_q[LAT];
        out_valid_d = out_valid_q & ~out_ready;
        out_data_d  = out_data_q;
        for (int l = 0; l < 2; l++) begin
            if (cap_v && (cap_lane == 1'(l))) begin
                out_valid_d[l] = 1'b1;
                out_data_d[l]  = path_outp[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= 1'b0;
            path_inp_q  <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            last_q      <= 1'b1;
            tag_v_q     <= '0;
            tag_lane_q  <= '0;
        end else begin
            sel_q       <= sel_d;
            path_inp_q  <= path_inp_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            last_q      <= last_d;
            tag_v_q     <= tag_v_d;
            tag_lane_q  <= tag_lane_d;
        end
    end

    assign sel       = sel_q;
    assign path_inp  = path_inp_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
